ram_bist: RTL
=============

RAM_BIST -- requirements
Module: ram_bist

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 8, data width of the RAM under test.
REQ-002 SHALL have parameter RAM_DEPTH, default 1024, number of RAM words tested.
REQ-003 SHALL have parameter ADDR_SIZE, default 10, RAM address width.
REQ-004 SHALL have parameter PATTERN, default 8'h55, background data pattern (RAM_WIDTH bits).
REQ-005 One clock; reset is asynchronous and active-high (clk, rst); no other clock or reset exists.
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port start, input, 1, begin test when sampled high in IDLE.
REQ-009 SHALL have port busy, output, 1, high while the test runs.
REQ-010 SHALL have port done, output, 1, high once a test completes; held until the next accepted start or reset.
REQ-011 SHALL have port pass, output, 1, high with done when no mismatch occurred.
REQ-012 SHALL have port fail, output, 1, sticky mismatch flag.
REQ-013 SHALL have port fail_addr, output, ADDR_SIZE, address of the first mismatch.
REQ-014 SHALL have port fail_data, output, RAM_WIDTH, data read at the first mismatch.
REQ-015 SHALL have ports ram_wr_en/ram_rd_en (1), ram_wr_add/ram_rd_add (ADDR_SIZE) and ram_data_in (RAM_WIDTH) as outputs driving the RAM's wr_en, rd_en, wr_add, rd_add and data_in.
REQ-016 SHALL have port ram_data_out, input, RAM_WIDTH, RAM read data, valid one cycle after ram_rd_en.

Function
REQ-017 FSM states SHALL be IDLE, W0, RW_RD, RW_WR, R1, R1_LAST and DONE.
REQ-018 IDLE: all RAM enables low; start=1 -> W0, addr=0, and done/pass/fail/fail_addr/fail_data cleared.
REQ-019 W0: ram_wr_en=1, ram_wr_add=addr, ram_data_in=PATTERN; addr+1 each cycle; at addr=RAM_DEPTH-1 -> RW_RD with addr=0.
REQ-020 RW_RD: ram_rd_en=1, ram_rd_add=addr -> RW_WR.
REQ-021 RW_WR: compare ram_data_out with PATTERN; ram_wr_en=1, ram_wr_add=addr, ram_data_in=~PATTERN; addr=RAM_DEPTH-1 -> R1 with addr=RAM_DEPTH-1, else addr+1 -> RW_RD.
REQ-022 R1 (descending): ram_rd_en=1, ram_rd_add=addr each cycle; the read issued in the previous cycle is compared with ~PATTERN; at addr=0 -> R1_LAST.
REQ-023 R1_LAST: compare the final read (address 0) only; no RAM enables; -> DONE.
REQ-024 DONE: done=1, pass=~fail, busy=0; -> IDLE on the next cycle while status holds.
REQ-025 Latency: done SHALL rise exactly 4*RAM_DEPTH+2 cycles after the edge that accepts start.
REQ-026 The first mismatch SHALL capture fail_addr/fail_data; later mismatches SHALL NOT overwrite them; the test SHALL always run to completion.
REQ-027 start SHALL be ignored while busy=1; ram_wr_en and ram_rd_en SHALL never be high in the same cycle.
REQ-028 Address counter SHALL not wrap; up/down terminal compares use RAM_DEPTH-1 and 0 exactly.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, addr=0, and all outputs (busy, done, pass, fail, fail_addr, fail_data, RAM enables, addresses, ram_data_in) to 0.
REQ-031 rst asserted mid-test SHALL abort with no further RAM writes; after release, a new start SHALL rerun the full test.

Verification (bench uses the team's ram with RAM_DEPTH=16, ADDR_SIZE=4)
REQ-032 Fault-free: start pulse -> busy=1 next cycle; done=1, pass=1, fail=0 exactly 66 cycles after the start edge; every mem word ends at 8'hAA.
REQ-033 Stuck cell: after W0, force mem[3]=8'h00 -> done at 66, fail=1, pass=0, fail_addr=3, fail_data=8'h00.
REQ-034 Two faults: corrupt mem[3] after W0 and mem[9] during R1 -> fail_addr stays 3.
REQ-035 start pulsed again at cycle 20 of a run -> ignored; done still at cycle 66.
REQ-036 rst pulsed at cycle 30 -> all outputs 0 asynchronously; re-start -> done 66 cycles later, pass=1.
REQ-037 Protocol check every cycle: never ram_wr_en and ram_rd_en both high; addresses always < 16.

Source files
------------

// File: rtl/ram_bist.sv
// rtl/ram_bist.sv - March-style RAM BIST: write pattern, read/invert ascending, read descending.
module ram_bist #(
    parameter int                   RAM_WIDTH = 8,
    parameter int                   RAM_DEPTH = 1024,
    parameter int                   ADDR_SIZE = 10,
    parameter logic [RAM_WIDTH-1:0] PATTERN   = 8'h55
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic [ADDR_SIZE-1:0] fail_addr,
    output logic [RAM_WIDTH-1:0] fail_data,
    output logic                 ram_wr_en,
    output logic                 ram_rd_en,
    output logic [ADDR_SIZE-1:0] ram_wr_add,
    output logic [ADDR_SIZE-1:0] ram_rd_add,
    output logic [RAM_WIDTH-1:0] ram_data_in,
    input  logic [RAM_WIDTH-1:0] ram_data_out
);

    localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(RAM_DEPTH - 1);

    typedef enum logic [2:0] {IDLE, W0, RW_RD, RW_WR, R1, R1_LAST, DONE} state_t;

    state_t               state, next_state;
    logic [ADDR_SIZE-1:0] addr, next_addr;
    logic [ADDR_SIZE-1:0] cmp_addr;
    logic                 r1_vld;
    logic                 start_accept;
    logic                 chk;
    logic [RAM_WIDTH-1:0] chk_exp;
    logic [ADDR_SIZE-1:0] chk_addr;
    logic                 mismatch;
    logic                 nx_wr_en, nx_rd_en;

    always_comb begin
        next_state   = state;
        next_addr    = addr;
        start_accept = 1'b0;
        chk          = 1'b0;
        chk_exp      = PATTERN;
        chk_addr     = addr;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state   = W0;
                    next_addr    = '0;
                    start_accept = 1'b1;
                end
            end
            W0: begin
                if (addr == LAST) begin
                    next_state = RW_RD;
                    next_addr  = '0;
                end else begin
                    next_addr = addr + 1'b1;
                end
            end
            RW_RD: next_state = RW_WR;
            RW_WR: begin
                chk = 1'b1;
                if (addr == LAST) begin
                    next_state = R1;
                end else begin
                    next_state = RW_RD;
                    next_addr  = addr + 1'b1;
                end
            end
            R1: begin
                // Read data lags one cycle, so the first R1 cycle has nothing to compare yet.
                chk      = r1_vld;
                chk_exp  = ~PATTERN;
                chk_addr = cmp_addr;
                if (addr == '0) begin
                    next_state = R1_LAST;
                end else begin
                    next_addr = addr - 1'b1;
                end
            end
            R1_LAST: begin
                chk        = 1'b1;
                chk_exp    = ~PATTERN;
                chk_addr   = cmp_addr;
                next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign mismatch = chk && (ram_data_out != chk_exp);
    assign nx_wr_en = (next_state == W0) || (next_state == RW_WR);
    assign nx_rd_en = (next_state == RW_RD) || (next_state == R1);

    // RAM controls are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= '0;
            cmp_addr    <= '0;
            r1_vld      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            fail_addr   <= '0;
            fail_data   <= '0;
            ram_wr_en   <= 1'b0;
            ram_rd_en   <= 1'b0;
            ram_wr_add  <= '0;
            ram_rd_add  <= '0;
            ram_data_in <= '0;
        end else begin
            state       <= next_state;
            addr        <= next_addr;
            r1_vld      <= (state == R1);
            if (state == R1) begin
                cmp_addr <= addr;
            end
            busy        <= (next_state != IDLE) && (next_state != DONE);
            ram_wr_en   <= nx_wr_en;
            ram_rd_en   <= nx_rd_en;
            ram_wr_add  <= nx_wr_en ? next_addr : '0;
            ram_rd_add  <= nx_rd_en ? next_addr : '0;
            ram_data_in <= (next_state == W0) ? PATTERN :
                           (next_state == RW_WR) ? ~PATTERN : '0;
            if (start_accept) begin
                done      <= 1'b0;
                pass      <= 1'b0;
                fail      <= 1'b0;
                fail_addr <= '0;
                fail_data <= '0;
            end else begin
                if (mismatch && !fail) begin
                    fail      <= 1'b1;
                    fail_addr <= chk_addr;
                    fail_data <= ram_data_out;
                end
                if (state == DONE) begin
                    done <= 1'b1;
                    pass <= ~fail;
                end
            end
        end
    end

endmodule
